// File: rtl/img_sram_pkg.sv
// Shared types and helpers for the image SRAM port: command struct, idle command,
// requester indices and the round-robin pick used by the arbiter.
package img_sram_pkg;

    localparam int IMG_ROW_W = 8;
    localparam int IMG_COL_W = 8;
    localparam int RR_MAX    = 8;

    localparam int REQ_RX   = 0;
    localparam int REQ_CONV = 1;
    localparam int REQ_TX   = 2;

    typedef struct packed {
        logic                 sense_en;
        logic                 write_en;
        logic [IMG_ROW_W-1:0] row;
        logic [IMG_COL_W-1:0] col;
        logic [7:0]           din;
    } img_sram_ctrl_t;

    localparam img_sram_ctrl_t IMG_SRAM_IDLE = '0;

    // One-hot pick of the first set req bit at or above ptr, wrapping at nreq.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                  input logic [2:0] ptr,
                                                  input int unsigned nreq);
        logic [RR_MAX-1:0] pick;
        logic              found;
        logic [3:0]        idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            idx = 4'(ptr) + 4'(i);
            if (idx >= 4'(nreq)) idx = idx - 4'(nreq);
            if (i < nreq && !found && req[idx[2:0]]) begin
                pick[idx[2:0]] = 1'b1;
                found          = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/img_sram_arbiter_rd_tracker.sv
// Read-ownership delay line: one-hot requester vector delayed by the SRAM read latency.
module img_sram_rd_tracker #(
    parameter int NREQ   = 3,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] push_vec,
    output logic [NREQ-1:0] valid_vec
);

    logic [NREQ-1:0] pipe [RD_LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= push_vec;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign valid_vec = pipe[RD_LAT-1];

endmodule

// File: rtl/img_sram_arbiter.sv
// Image SRAM port arbiter: round-robin with bounded burst lock, zero-latency command mux,
// and read-data steering back to the issuing requester.
module img_sram_arbiter
    import img_sram_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    input  img_sram_ctrl_t  req_ctrl [NREQ],
    output logic [NREQ-1:0] gnt,
    output img_sram_ctrl_t  sram_ctrl,
    input  logic [7:0]      sram_dout,
    output logic [NREQ-1:0] rd_valid,
    output logic [7:0]      rd_data
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] gnt_idx;
    logic             owner_vld;
    logic [CNT_W-1:0] lock_cnt;
    logic [NREQ-1:0]  owner_oh;
    logic [NREQ-1:0]  rr_gnt;
    logic [NREQ-1:0]  push_vec;
    logic             lock_expired;
    logic             cont;

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
        // Expiry only bites when someone else is actually waiting.
        lock_expired = (MAX_LOCK != 0) && (int'(lock_cnt) >= MAX_LOCK - 1)
                       && (|(req & ~owner_oh));
        cont   = owner_vld && req[owner] && lock[owner] && !lock_expired;
        rr_gnt = NREQ'(rr_pick(RR_MAX'(req), 3'(rr_ptr), NREQ));
        if (!rstn)     gnt = '0;
        else if (cont) gnt = owner_oh;
        else           gnt = rr_gnt;
    end

    always_comb begin
        gnt_idx   = '0;
        sram_ctrl = IMG_SRAM_IDLE;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx   = IDX_W'(i);
                sram_ctrl = req_ctrl[i];
            end
        end
        push_vec = (sram_ctrl.sense_en && !sram_ctrl.write_en) ? gnt : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            lock_cnt  <= '0;
        end else if (|gnt) begin
            owner     <= gnt_idx;
            owner_vld <= lock[gnt_idx];
            if (cont) begin
                // Saturate; the expiry compare only needs to reach MAX_LOCK-1.
                if (int'(lock_cnt) < MAX_LOCK - 1) lock_cnt <= lock_cnt + 1'b1;
            end else begin
                lock_cnt <= '0;
                rr_ptr   <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            end
        end else begin
            owner_vld <= 1'b0;
            lock_cnt  <= '0;
        end
    end

    img_sram_rd_tracker #(
        .NREQ   (NREQ),
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk       (clk),
        .rstn      (rstn),
        .push_vec  (push_vec),
        .valid_vec (rd_valid)
    );

    assign rd_data = sram_dout;

endmodule

// File: tb/tb_img_sram_arbiter.sv
// Bench for img_sram_arbiter: three instances (default, MAX_LOCK=8, RD_LAT=3) share stimulus.
module tb_img_sram_arbiter;
    import img_sram_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [2:0]     req, lock;
    img_sram_ctrl_t ctrl [3];
    logic [2:0]     gnt_a, rv_a, gnt_b, rv_b, gnt_c, rv_c;
    img_sram_ctrl_t sc_a, sc_b, sc_c;
    logic [7:0]     rd_a, rd_b, rd_c, dout_a, dout_zero;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] rv;
        logic [7:0] data;
    } rd_exp_t;
    rd_exp_t sb [$];

    typedef struct {
        logic [2:0] req;
        logic [2:0] lock;
        logic [1:0] sw;
        logic [2:0] gnt;
    } vec_t;
    vec_t tbl [12];

    assign dout_zero = 8'h00;

    img_sram_arbiter u_a (
        .clk(clk), .rstn(rstn), .req(req), .lock(lock), .req_ctrl(ctrl), .gnt(gnt_a),
        .sram_ctrl(sc_a), .sram_dout(dout_a), .rd_valid(rv_a), .rd_data(rd_a));

    img_sram_arbiter #(.MAX_LOCK(8)) u_b (
        .clk(clk), .rstn(rstn), .req(req), .lock(lock), .req_ctrl(ctrl), .gnt(gnt_b),
        .sram_ctrl(sc_b), .sram_dout(dout_zero), .rd_valid(rv_b), .rd_data(rd_b));

    img_sram_arbiter #(.RD_LAT(3)) u_c (
        .clk(clk), .rstn(rstn), .req(req), .lock(lock), .req_ctrl(ctrl), .gnt(gnt_c),
        .sram_ctrl(sc_c), .sram_dout(dout_zero), .rd_valid(rv_c), .rd_data(rd_c));

    function automatic logic [7:0] mem_val(input logic [7:0] row, input logic [7:0] col);
        return (row * 8'd7) ^ col ^ 8'h5A;
    endfunction

    // SRAM model for instance a: one-cycle read latency
    always @(posedge clk)
        if (sc_a.sense_en && !sc_a.write_en) dout_a <= mem_val(sc_a.row, sc_a.col);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_cmds(input int k, input logic s, input logic w);
        for (int i = 0; i < 3; i++)
            ctrl[i] = '{sense_en: s, write_en: w, row: 8'(k * 16 + i),
                        col: 8'(k + i * 5), din: 8'(k ^ i)};
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_ctrl_a", 32'(sc_a), 32'(IMG_SRAM_IDLE));
        chk("rst_rv_a", 32'(rv_a), 32'd0);
        chk("rst_gnt_c", 32'(gnt_c), 32'd0);
        chk("rst_rv_c", 32'(rv_c), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        sb.delete();
        sb.push_back('0);
    endtask

    // One cycle on instance a: check grant/command now, read return via scoreboard
    task automatic tick_a(input logic [2:0] exp_gnt);
        int             g;
        rd_exp_t        e;
        img_sram_ctrl_t ec;
        @(negedge clk);
        g  = -1;
        ec = IMG_SRAM_IDLE;
        for (int i = 0; i < 3; i++) if (exp_gnt[i]) begin g = i; ec = ctrl[i]; end
        chk("gnt_a", 32'(gnt_a), 32'(exp_gnt));
        chk("sram_ctrl_a", 32'(sc_a), 32'(ec));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("rd_valid_a", 32'(rv_a), 32'(e.rv));
            if (e.rv != 3'b000) chk("rd_data_a", 32'(rd_a), 32'(e.data));
        end
        e.rv   = (g >= 0 && ec.sense_en && !ec.write_en) ? exp_gnt : 3'b000;
        e.data = mem_val(ec.row, ec.col);
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] ea, eb, erb, ec3, erc;
        //            req     lock    sw     gnt
        tbl[0]  = '{3'b111, 3'b000, 2'b10, 3'b001};
        tbl[1]  = '{3'b111, 3'b000, 2'b10, 3'b010};
        tbl[2]  = '{3'b111, 3'b000, 2'b10, 3'b100};
        tbl[3]  = '{3'b111, 3'b000, 2'b10, 3'b001};
        tbl[4]  = '{3'b101, 3'b000, 2'b11, 3'b100};
        tbl[5]  = '{3'b110, 3'b000, 2'b00, 3'b010};
        tbl[6]  = '{3'b011, 3'b000, 2'b10, 3'b001};
        tbl[7]  = '{3'b000, 3'b000, 2'b10, 3'b000};
        tbl[8]  = '{3'b001, 3'b000, 2'b10, 3'b001};
        tbl[9]  = '{3'b010, 3'b010, 2'b10, 3'b010};
        tbl[10] = '{3'b011, 3'b010, 2'b10, 3'b010};
        tbl[11] = '{3'b011, 3'b000, 2'b10, 3'b001};

        // Reset with all requesters asserted, then idle
        req  = 3'b111;
        lock = 3'b000;
        set_cmds(0, 1'b1, 1'b0);
        do_reset();
        req = 3'b000;
        repeat (10) tick_a(3'b000);

        // Round-robin, writes, NOPs and lock hand-off
        for (int k = 0; k < 12; k++) begin
            req  = tbl[k].req;
            lock = tbl[k].lock;
            set_cmds(k + 1, tbl[k].sw[1], tbl[k].sw[0]);
            tick_a(tbl[k].gnt);
        end
        req  = 3'b000;
        lock = 3'b000;
        tick_a(3'b000);

        // Locked write burst by RX with TX waiting from cycle 5
        do_reset();
        for (int t = 0; t <= 20; t++) begin
            req     = {t >= 5, 1'b0, 1'b1};
            lock    = (t < 20) ? 3'b001 : 3'b000;
            ctrl[0] = '{sense_en: 1'b1, write_en: 1'b1, row: 8'(t), col: 8'(t), din: 8'(t)};
            ctrl[1] = IMG_SRAM_IDLE;
            ctrl[2] = '{sense_en: 1'b1, write_en: 1'b0, row: 8'(t), col: 8'h33, din: 8'h00};
            ea  = (t == 20) ? 3'b100 : 3'b001;
            eb  = (t == 8 || t == 17 || t == 20) ? 3'b100 : 3'b001;
            erb = (t == 9 || t == 18) ? 3'b100 : 3'b000;
            @(negedge clk);
            chk("lock64_gnt", 32'(gnt_a), 32'(ea));
            chk("lock64_rv", 32'(rv_a), 32'd0);
            chk("lock8_gnt", 32'(gnt_b), 32'(eb));
            chk("lock8_rv", 32'(rv_b), 32'(erb));
            @(posedge clk); #1;
        end
        req  = 3'b000;
        lock = 3'b000;

        // RD_LAT=3: reads by 1 then 2, then a write by 0
        do_reset();
        ctrl[0] = '{sense_en: 1'b1, write_en: 1'b1, row: 8'h01, col: 8'h02, din: 8'hA5};
        ctrl[1] = '{sense_en: 1'b1, write_en: 1'b0, row: 8'h11, col: 8'h12, din: 8'h00};
        ctrl[2] = '{sense_en: 1'b1, write_en: 1'b0, row: 8'h21, col: 8'h22, din: 8'h00};
        for (int t = 0; t < 7; t++) begin
            req = (t == 0) ? 3'b010 : (t == 1) ? 3'b100 : (t == 2) ? 3'b001 : 3'b000;
            ec3 = req;
            erc = (t == 3) ? 3'b010 : (t == 4) ? 3'b100 : 3'b000;
            @(negedge clk);
            chk("lat3_gnt", 32'(gnt_c), 32'(ec3));
            chk("lat3_rv", 32'(rv_c), 32'(erc));
            @(posedge clk); #1;
        end

        // Reset pulse with two reads in flight and a lock held
        do_reset();
        set_cmds(20, 1'b1, 1'b0);
        req  = 3'b001;
        lock = 3'b001;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            chk("pre_rst_gnt", 32'(gnt_c), 32'b001);
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_gnt", 32'(gnt_c), 32'd0);
        chk("mid_rst_rv", 32'(rv_c), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        req  = 3'b111;
        lock = 3'b000;
        for (int t = 3; t < 7; t++) begin
            ec3 = (t == 3 || t == 6) ? 3'b001 : (t == 4) ? 3'b010 : 3'b100;
            erc = (t == 6) ? 3'b001 : 3'b000;
            @(negedge clk);
            chk("post_rst_gnt", 32'(gnt_c), 32'(ec3));
            chk("post_rst_rv", 32'(rv_c), 32'(erc));
            @(posedge clk); #1;
        end
        req = 3'b000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
